// File: rtl/jtkcpu_intctl_pkg.sv
// Shared constants for the KONAMI-1 interrupt controller: vector addresses,
// one-hot cur_int bit positions and the controller state encoding.
package jtkcpu_intctl_pkg;

    localparam int INT_IRQ  = 0;
    localparam int INT_FIRQ = 1;
    localparam int INT_NMI  = 2;
    localparam int INT_RST  = 3;

    localparam logic [15:0] VEC_RST  = 16'hFFFE;
    localparam logic [15:0] VEC_NMI  = 16'hFFFC;
    localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
    localparam logic [15:0] VEC_IRQ  = 16'hFFF8;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } int_state_t;

    // cur_int is one-hot; anything else (including zero) maps to no vector
    function automatic logic [15:0] vec_of(input logic [3:0] cur);
        logic [15:0] v;
        v = 16'h0000;
        case (cur)
            4'b1000: v = VEC_RST;
            4'b0100: v = VEC_NMI;
            4'b0010: v = VEC_FIRQ;
            4'b0001: v = VEC_IRQ;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jtkcpu_sync.sv
// Input synchroniser: SYNC_STAGES flops advanced only on cen, reset to 1
// so an active-low line reads inactive out of reset.
module jtkcpu_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '1;
        end else if (cen) begin
            sr[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[SYNC_STAGES-1];

endmodule

// File: rtl/jtkcpu_intctl.sv
// KONAMI-1 interrupt controller: synchronises NMI/FIRQ/IRQ, latches armed NMI
// edges, grants one source per instruction boundary and holds it until fetch.
module jtkcpu_intctl
    import jtkcpu_intctl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        nmi_n,
    input  logic        firq_n,
    input  logic        irq_n,
    input  logic        cc_i,
    input  logic        cc_f,
    input  logic        s_wr,
    input  logic        ni,
    input  logic        op_fetch,
    input  logic        int_en,
    output logic        intsrv,
    output logic        int_go,
    output logic [3:0]  cur_int,
    output logic [3:0]  intvec,
    output logic [15:0] vec_addr,
    output logic        full_frame
);

    logic       nmi_s, firq_s, irq_s;
    logic       nmi_s_l;
    logic       nmi_arm, nmi_pend;
    logic       nmi_edge;
    logic       firq_req, irq_req;
    logic       grant;
    logic [3:0] sel;
    int_state_t state;

    jtkcpu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk(clk), .rst(rst), .cen(cen), .din(nmi_n), .dout(nmi_s)
    );
    jtkcpu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_firq (
        .clk(clk), .rst(rst), .cen(cen), .din(firq_n), .dout(firq_s)
    );
    jtkcpu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
        .clk(clk), .rst(rst), .cen(cen), .din(irq_n), .dout(irq_s)
    );

    assign nmi_edge = nmi_arm & nmi_s_l & ~nmi_s;
    assign firq_req = ~firq_s & ~cc_f;
    assign irq_req  = ~irq_s & ~cc_i;
    assign intsrv   = nmi_pend | firq_req | irq_req;
    assign grant    = cen & ~rst & ni & intsrv;
    assign int_go   = grant;

    always_comb begin
        sel = 4'b0000;
        if (nmi_pend)      sel[INT_NMI]  = 1'b1;
        else if (firq_req) sel[INT_FIRQ] = 1'b1;
        else               sel[INT_IRQ]  = 1'b1;
    end

    // An edge arriving with an NMI grant wins, so back-to-back NMIs are kept
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_s_l  <= 1'b1;
            nmi_arm  <= 1'b0;
            nmi_pend <= 1'b0;
        end else if (cen) begin
            nmi_s_l <= nmi_s;
            if (s_wr) nmi_arm <= 1'b1;
            if (nmi_edge)
                nmi_pend <= 1'b1;
            else if (grant && sel[INT_NMI])
                nmi_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SERVE;
            cur_int <= 4'b1000;
        end else if (cen) begin
            if (grant) begin
                state   <= SERVE;
                cur_int <= sel;
            end else if (op_fetch && state == SERVE) begin
                state   <= IDLE;
                cur_int <= 4'b0000;
            end
        end
    end

    assign intvec     = cur_int & {4{int_en}};
    assign vec_addr   = vec_of(cur_int);
    assign full_frame = ~cur_int[INT_FIRQ];

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Directed bench for jtkcpu_intctl: reset state, NMI arming/edges, FIRQ/IRQ
// priority and masking, same-cycle NMI re-trigger, cen freeze, mid-handler reset.
module tb_jtkcpu_intctl;
    import jtkcpu_intctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic        nmi_n, firq_n, irq_n, cc_i, cc_f;
    logic        s_wr, ni, op_fetch, int_en;
    logic        intsrv, int_go, full_frame;
    logic [3:0]  cur_int, intvec;
    logic [15:0] vec_addr;

    int checks = 0;
    int errors = 0;

    jtkcpu_intctl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
        .cc_i(cc_i), .cc_f(cc_f), .s_wr(s_wr), .ni(ni),
        .op_fetch(op_fetch), .int_en(int_en),
        .intsrv(intsrv), .int_go(int_go), .cur_int(cur_int),
        .intvec(intvec), .vec_addr(vec_addr), .full_frame(full_frame)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_ni();
        ni = 1'b1;
        tick(1);
        ni = 1'b0;
    endtask

    task automatic pulse_fetch();
        op_fetch = 1'b1;
        tick(1);
        op_fetch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1;
        nmi_n = 1'b1; firq_n = 1'b1; irq_n = 1'b1;
        cc_i = 1'b1; cc_f = 1'b1;
        s_wr = 1'b0; ni = 1'b0; op_fetch = 1'b0; int_en = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_cur_int", {12'h0, cur_int}, 16'h0008);
        check("rst_vec", vec_addr, 16'hFFFE);
        check("rst_full", {15'h0, full_frame}, 16'h0001);
        check("rst_int_go", {15'h0, int_go}, 16'h0000);
        check("rst_intsrv", {15'h0, intsrv}, 16'h0000);
        check("rst_state", {15'h0, dut.state}, {15'h0, SERVE});
        check("rst_intvec_off", {12'h0, intvec}, 16'h0000);
        int_en = 1'b1; #1;
        check("rst_intvec_on", {12'h0, intvec}, 16'h0008);
        int_en = 1'b0;

        pulse_fetch();
        check("fetch_cur_int", {12'h0, cur_int}, 16'h0000);
        check("fetch_vec", vec_addr, 16'h0000);
        check("fetch_state", {15'h0, dut.state}, {15'h0, IDLE});

        // NMI before arming is ignored and not remembered
        nmi_n = 1'b0;
        tick(4);
        check("unarmed_pend", {15'h0, dut.nmi_pend}, 16'h0000);
        check("unarmed_intsrv", {15'h0, intsrv}, 16'h0000);
        ni = 1'b1; #1;
        check("unarmed_go", {15'h0, int_go}, 16'h0000);
        tick(1); ni = 1'b0;
        check("unarmed_cur", {12'h0, cur_int}, 16'h0000);
        nmi_n = 1'b1;
        tick(4);

        // Arm, then NMI edge: intsrv after 2 sync + 1 edge cycle
        s_wr = 1'b1; tick(1); s_wr = 1'b0;
        check("armed_no_pend", {15'h0, dut.nmi_pend}, 16'h0000);
        nmi_n = 1'b0;
        tick(2);
        check("nmi_lat2", {15'h0, intsrv}, 16'h0000);
        tick(1);
        check("nmi_lat3", {15'h0, intsrv}, 16'h0001);
        ni = 1'b1; #1;
        check("nmi_go", {15'h0, int_go}, 16'h0001);
        tick(1); ni = 1'b0;
        check("nmi_go_drop", {15'h0, int_go}, 16'h0000);
        check("nmi_cur", {12'h0, cur_int}, 16'h0004);
        check("nmi_vec", vec_addr, 16'hFFFC);
        check("nmi_full", {15'h0, full_frame}, 16'h0001);
        check("nmi_pend_clr", {15'h0, dut.nmi_pend}, 16'h0000);
        pulse_fetch();
        check("nmi_fetch_cur", {12'h0, cur_int}, 16'h0000);
        nmi_n = 1'b1;
        tick(3);

        // FIRQ beats IRQ; then FIRQ masked lets IRQ through
        firq_n = 1'b0; irq_n = 1'b0; cc_f = 1'b0; cc_i = 1'b0;
        tick(2);
        check("firq_intsrv", {15'h0, intsrv}, 16'h0001);
        pulse_ni();
        check("firq_cur", {12'h0, cur_int}, 16'h0002);
        check("firq_vec", vec_addr, 16'hFFF6);
        check("firq_full", {15'h0, full_frame}, 16'h0000);
        pulse_fetch();
        cc_f = 1'b1;
        pulse_ni();
        check("irq_cur", {12'h0, cur_int}, 16'h0001);
        check("irq_vec", vec_addr, 16'hFFF8);
        check("irq_full", {15'h0, full_frame}, 16'h0001);
        int_en = 1'b1; #1;
        check("irq_intvec", {12'h0, intvec}, 16'h0001);
        int_en = 1'b0;
        // Mask after the grant does not revoke it
        cc_i = 1'b1;
        tick(1);
        check("irq_kept", {12'h0, cur_int}, 16'h0001);
        pulse_fetch();
        firq_n = 1'b1; irq_n = 1'b1;
        tick(3);

        // IRQ masked, then unmasked
        irq_n = 1'b0; cc_i = 1'b1;
        tick(3);
        check("irqm_intsrv", {15'h0, intsrv}, 16'h0000);
        ni = 1'b1; #1;
        check("irqm_go", {15'h0, int_go}, 16'h0000);
        tick(1); ni = 1'b0;
        check("irqm_cur", {12'h0, cur_int}, 16'h0000);
        cc_i = 1'b0; #1;
        check("irqu_intsrv", {15'h0, intsrv}, 16'h0001);
        pulse_ni();
        check("irqu_cur", {12'h0, cur_int}, 16'h0001);
        pulse_fetch();
        irq_n = 1'b1; cc_i = 1'b1;
        tick(3);

        // New NMI edge in the same cycle as an NMI grant keeps nmi_pend
        nmi_n = 1'b0;
        tick(3);
        check("nmi2_pend", {15'h0, dut.nmi_pend}, 16'h0001);
        nmi_n = 1'b1;
        tick(3);
        nmi_n = 1'b0;
        tick(2);
        ni = 1'b1; #1;
        check("nmi2_go", {15'h0, int_go}, 16'h0001);
        tick(1); ni = 1'b0;
        check("nmi2_pend_kept", {15'h0, dut.nmi_pend}, 16'h0001);
        check("nmi2_cur", {12'h0, cur_int}, 16'h0004);
        ni = 1'b1; #1;
        check("nmi3_go", {15'h0, int_go}, 16'h0001);
        tick(1); ni = 1'b0;
        check("nmi3_cur", {12'h0, cur_int}, 16'h0004);
        check("nmi3_pend_clr", {15'h0, dut.nmi_pend}, 16'h0000);
        pulse_fetch();
        check("nmi3_fetch", {12'h0, cur_int}, 16'h0000);
        nmi_n = 1'b1;
        tick(3);

        // cen=0 freezes everything and masks int_go
        cen = 1'b0;
        nmi_n = 1'b0;
        tick(5);
        check("frz_pend", {15'h0, dut.nmi_pend}, 16'h0000);
        check("frz_intsrv", {15'h0, intsrv}, 16'h0000);
        cc_i = 1'b0; irq_n = 1'b0; ni = 1'b1; #1;
        check("frz_go", {15'h0, int_go}, 16'h0000);
        tick(1); ni = 1'b0; cc_i = 1'b1; irq_n = 1'b1;
        check("frz_cur", {12'h0, cur_int}, 16'h0000);
        cen = 1'b1;
        tick(2);
        check("thaw_lat2", {15'h0, intsrv}, 16'h0000);
        tick(1);
        check("thaw_lat3", {15'h0, intsrv}, 16'h0001);
        pulse_ni();
        check("thaw_cur", {12'h0, cur_int}, 16'h0004);

        // Reset mid-handler aborts service, drops arming and pending NMI
        nmi_n = 1'b1;
        tick(3);
        nmi_n = 1'b0;
        tick(3);
        check("pre_rst_pend", {15'h0, dut.nmi_pend}, 16'h0001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_cur", {12'h0, cur_int}, 16'h0008);
        check("mid_rst_vec", vec_addr, 16'hFFFE);
        check("mid_rst_pend", {15'h0, dut.nmi_pend}, 16'h0000);
        check("mid_rst_arm", {15'h0, dut.nmi_arm}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no end expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
